countdown_display: RTL and testbench
====================================

# countdown_display

Display-side consumer of the traffic controller's countdown interface. Samples `led_en`/`led_data`, converts the 6-bit binary count to two BCD digits with a sequential double-dabble converter, and drives a two-digit multiplexed 7-segment display. Sits between the traffic controller and the board's display pins.

## Interface

- `SCAN_DIV`, default 50000: clk cycles per digit scan slot; legal range 2..2^20.
- `clk` input 1: system clock, all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `led_en` input 1: display enable from the controller; high shows the countdown.
- `led_data` input 6: binary countdown value, 0..63.
- `seg` output 7: segment drive, active-high, bit0 = a … bit6 = g.
- `dig_sel` output 2: one-hot digit enable, active-high; `01` = ones, `10` = tens, `00` = all off.
- `busy` output 1: high while a conversion is in progress.

## Operation

- **Input stage.** `data_q`/`en_q` register `led_data`/`led_en` every cycle. `last_q` holds the last value sent to the converter. The `stale` flag is set by reset and cleared on the first conversion start.
- **Converter FSM: IDLE → SHIFT → IDLE.**
  - IDLE: if `stale` or `data_q != last_q`, load the shift register with `data_q`, clear the BCD field, set `last_q <= data_q`, zero the iteration counter, and go to SHIFT.
  - SHIFT: each cycle, add 3 to any BCD nibble ≥5, then shift left by one. Six iterations total.
  - On the 6th iteration, latch `tens`/`ones` from the final BCD value and return to IDLE.
  - `busy` = (state == SHIFT).
- **Range.** `tens` is 0..6 and `ones` is 0..9. 63 gives tens=6, ones=3.
- **Input changes during a conversion** are ignored until IDLE. IDLE then compares against `last_q`, so the final settled value is always converted. Intermediate values may be skipped.
- **Scan.**
  - The prescaler counts 0..`SCAN_DIV`-1 and wraps.
  - On wrap, the digit index toggles: ones → tens → ones.
  - The prescaler runs independently of `en_q` and the FSM.
- **Output drive (registered).**
  - If `en_q` = 0: `dig_sel` = `00`, `seg` = 0.
  - Otherwise `dig_sel` = one-hot of the digit index.
  - `seg` = segment pattern of the selected digit.
  - Tens digit with `tens` = 0: `seg` = 0 (leading-zero blank), but `dig_sel` still = `10`.
  - Ones digit: always shown, including 0.

## Timing

- **Reset values.** `seg` = 0, `dig_sel` = `00`, `busy` = 0. Internally: FSM IDLE, prescaler 0, digit index = ones, `tens` = `ones` = 0, `last_q` = 0, `stale` = 1, `data_q` = 0, `en_q` = 0.
- **Conversion latency.** Let `led_data` be sampled into `data_q` at edge k.
  - Edge k+1: conversion loads, and `busy` rises.
  - Edges k+2..k+7: the six shift iterations. `tens`/`ones` update at k+7 and `busy` falls at k+7.
  - Edge k+8: `seg` shows the new digit, if that digit is selected.
- **Enable latency.** A `led_en` change reaches `dig_sel` two edges after it is applied: sample, then output register.
- **Reset mid-conversion.** Everything returns to reset values immediately. Because `stale` = 1, the first IDLE cycle after reset release re-converts.
- **Prescaler wrap and conversion latch on the same edge.** Both take effect. The next digit shows the new value from the following edge.
- **Constant input.** No further conversions occur and `busy` stays 0.

## Structure

- **Shared package `traffic_pkg`:**
  - Segment constants `SEG_0`..`SEG_9` and `SEG_BLANK` (a=bit0).
  - Converter state typedef (IDLE, SHIFT).
  - Digit-select encodings `DIG_ONES` = `01`, `DIG_TENS` = `10`, `DIG_OFF` = `00`.
- **Sub-module `bin2bcd_seq`.**
  - Inputs: `clk`, `rst_n`, `start`, 6-bit `bin`.
  - Outputs: `busy`, `done` (1-cycle pulse), 4-bit `tens`, 4-bit `ones`.
  - Contains the FSM, iteration counter, and shift register.
  - The top level holds the input stage, change detection, prescaler/scan logic, and output registers.

## Test plan

- **Reset then enable:** release `rst_n` with `led_en` = 1 and `led_data` = 0. Expect exactly one conversion (`busy` high for 6 cycles). The ones slot shows `SEG_0`; the tens slot has `dig_sel` = `10` and `seg` = 0.
- **Conversion latency (`SCAN_DIV` = 4):** with `led_data` = 40, expect `busy` high for edges k+1..k+6 and low at k+7. `seg` = `SEG_4` in the tens slot and `SEG_0` in the ones slot from k+8.
- **Maximum value:** `led_data` = 63 gives tens = `SEG_6`, ones = `SEG_3`. `led_data` = 9 blanks the tens digit and shows `SEG_9` in the ones digit.
- **Mid-conversion change:** apply 30, then 29 two cycles later. The first conversion completes, a second one follows, and the final display shows 2 and 9.
- **Enable off:** with `led_en` = 0, hold `dig_sel` = `00` and `seg` = 0 for 100 cycles while the prescaler keeps running. Re-enabling restores the display two edges later.
- **Async reset mid-SHIFT:** assert `rst_n` = 0 during the 3rd iteration. Outputs clear without waiting for a clock edge. After release, one fresh conversion of the current `led_data` runs.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light display path: segment glyphs,
// digit-select codes and the binary-to-BCD converter state type.
package traffic_pkg;

    typedef enum logic [0:0] {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_t;

    // Segment patterns, bit0 = a ... bit6 = g, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_OFF  = 2'b00;
    localparam logic [1:0] DIG_ONES = 2'b01;
    localparam logic [1:0] DIG_TENS = 2'b10;

    localparam int BCD_ITERS = 6;

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 6-bit binary to two BCD digits,
// one add-3/shift iteration per clock, six iterations per conversion.
module bin2bcd_seq
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    localparam logic [2:0] LAST_ITER = 3'(BCD_ITERS - 1);

    conv_state_t state_q, state_d;
    logic [2:0]  iter_q, iter_d;
    // {tens nibble, ones nibble, binary operand}
    logic [13:0] sr_q, sr_d;
    logic [13:0] sr_adj, sr_shift;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        done_q, done_d;

    always_comb begin
        sr_adj = sr_q;
        if (sr_adj[13:10] >= 4'd5) sr_adj[13:10] = sr_adj[13:10] + 4'd3;
        if (sr_adj[9:6] >= 4'd5)   sr_adj[9:6]   = sr_adj[9:6] + 4'd3;
        sr_shift = {sr_adj[12:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        sr_d    = sr_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    sr_d    = {8'd0, bin};
                    iter_d  = 3'd0;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                sr_d = sr_shift;
                if (iter_q == LAST_ITER) begin
                    tens_d  = sr_shift[13:10];
                    ones_d  = sr_shift[9:6];
                    done_d  = 1'b1;
                    state_d = CONV_IDLE;
                end else begin
                    iter_d = iter_q + 3'd1;
                end
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
            iter_q  <= 3'd0;
            sr_q    <= 14'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            sr_q    <= sr_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == CONV_SHIFT);
    assign done = done_q;
    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/countdown_display.sv
// Countdown display driver: samples the controller's count, converts it to
// BCD on change, and multiplexes two 7-segment digits.
module countdown_display
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       led_en,
    input  logic [5:0] led_data,
    output logic [6:0] seg,
    output logic [1:0] dig_sel,
    output logic       busy
);

    localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [5:0]    data_q, last_q;
    logic          en_q, stale_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          digit_q, digit_d;   // 0 = ones slot, 1 = tens slot
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    sel_q, sel_d;

    logic          conv_start, conv_busy, conv_done_unused;
    logic [3:0]    conv_tens, conv_ones;

    // Re-convert after reset or whenever the settled input differs from the last one converted.
    assign conv_start = !conv_busy && (stale_q || (data_q != last_q));

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (data_q),
        .busy  (conv_busy),
        .done  (conv_done_unused),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    always_comb begin
        presc_d = presc_q + PW'(1);
        digit_d = digit_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            digit_d = !digit_q;
        end
    end

    always_comb begin
        sel_d = DIG_OFF;
        seg_d = SEG_BLANK;
        if (en_q) begin
            if (digit_q) begin
                sel_d = DIG_TENS;
                seg_d = (conv_tens == 4'd0) ? SEG_BLANK : seg_of(conv_tens);
            end else begin
                sel_d = DIG_ONES;
                seg_d = seg_of(conv_ones);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 6'd0;
            en_q    <= 1'b0;
            last_q  <= 6'd0;
            stale_q <= 1'b1;
            presc_q <= '0;
            digit_q <= 1'b0;
            seg_q   <= SEG_BLANK;
            sel_q   <= DIG_OFF;
        end else begin
            data_q  <= led_data;
            en_q    <= led_en;
            if (conv_start) begin
                last_q  <= data_q;
                stale_q <= 1'b0;
            end
            presc_q <= presc_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = sel_q;
    assign busy    = conv_busy;

endmodule

// File: tb/tb_countdown_display.sv
// Scoreboard bench for countdown_display: an arithmetic reference model
// predicts each cycle's outputs, a monitor compares them against the DUT.
module tb_countdown_display;

    localparam int SCAN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       led_en = 1'b1;
    logic [5:0] led_data = 6'd0;
    logic [6:0] seg;
    logic [1:0] dig_sel;
    logic       busy;

    countdown_display #(.SCAN_DIV(SCAN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .led_en   (led_en),
        .led_data (led_data),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] sel;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_new;
    exp_t e_got;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Glyphs written out from the lit segment letters (a = bit0 .. g = bit6).
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b0111111; // a b c d e f
            1: return 7'b0000110; // b c
            2: return 7'b1011011; // a b d e g
            3: return 7'b1001111; // a b c d g
            4: return 7'b1100110; // b c f g
            5: return 7'b1101101; // a c d f g
            6: return 7'b1111101; // a c d e f g
            7: return 7'b0000111; // a b c
            8: return 7'b1111111;
            9: return 7'b1101111; // a b c d f g
            default: return 7'b0000000;
        endcase
    endfunction

    // Reference model: conversion is a 6-cycle busy window ending in value/10, value%10.
    int m_data, m_last, m_conv, m_left, m_tens, m_ones, m_presc;
    bit m_en, m_stale, m_digit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data = 0; m_last = 0; m_conv = 0; m_left = 0;
            m_tens = 0; m_ones = 0; m_presc = 0;
            m_en = 0; m_stale = 1; m_digit = 0;
            exp_q.delete();
        end else begin
            if (!m_en) begin
                e_new.sel = 2'b00;
                e_new.seg = 7'd0;
            end else if (m_digit) begin
                e_new.sel = 2'b10;
                e_new.seg = (m_tens == 0) ? 7'd0 : glyph(m_tens);
            end else begin
                e_new.sel = 2'b01;
                e_new.seg = glyph(m_ones);
            end
            if (m_left == 0) begin
                if (m_stale || m_data != m_last) begin
                    m_conv  = m_data;
                    m_last  = m_data;
                    m_stale = 0;
                    m_left  = 6;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_tens = m_conv / 10;
                    m_ones = m_conv % 10;
                end
            end
            m_presc = m_presc + 1;
            if (m_presc == SCAN) begin
                m_presc = 0;
                m_digit = !m_digit;
            end
            m_data = int'(led_data);
            m_en   = led_en;
            e_new.busy = (m_left != 0);
            exp_q.push_back(e_new);
        end
    end

    // Monitor: during reset outputs must already be cleared; otherwise pop and compare.
    always begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            #1;
            n_cmp++;
            if (seg !== 7'd0 || dig_sel !== 2'b00 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state t=%0t: seg=%h dig_sel=%b busy=%b, required seg=00 dig_sel=00 busy=0",
                         $time, seg, dig_sel, busy);
            end
        end else if (exp_q.size() > 0) begin
            e_got = exp_q.pop_front();
            n_cmp++;
            if (seg !== e_got.seg || dig_sel !== e_got.sel || busy !== e_got.busy) begin
                n_fail++;
                $display("FAIL display t=%0t: seg=%h dig_sel=%b busy=%b, required seg=%h dig_sel=%b busy=%b",
                         $time, seg, dig_sel, busy, e_got.seg, e_got.sel, e_got.busy);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        led_en   = 1'b1;
        led_data = 6'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(20);

        led_data = 6'd40; step(20);
        led_data = 6'd63; step(20);
        led_data = 6'd9;  step(20);
        led_data = 6'd30; step(2);
        led_data = 6'd29; step(30);

        led_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            led_data = 6'($urandom_range(0, 63));
            step(10);
        end
        led_data = 6'd17; step(12);
        led_en = 1'b1;    step(20);

        // Reset lands inside the third shift iteration of converting 57.
        led_data = 6'd57;
        step(4);
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(20);

        for (int i = 0; i < 300; i++) begin
            led_data = 6'($urandom_range(0, 63));
            led_en   = ($urandom_range(0, 7) != 0);
            step(int'($urandom_range(1, 12)));
        end
        led_en = 1'b1;
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
